// File: rtl/lane_settle_monitor_if.sv
// Bus bundle between a lane-array stimulus source and the settle monitor.
// master drives the lane samples and control; slave is the monitor.
interface lane_settle_monitor_if #(
    parameter int LANES = 1,
    parameter int CNTW  = 8
);
    logic [LANES-1:0] lane_in;
    logic [LANES-1:0] expect_val;
    logic             clear;
    logic             locked;
    logic             fail;
    logic [CNTW-1:0]  settle_cycles;
    logic [CNTW-1:0]  glitch_count;
    logic [LANES-1:0] mismatch_seen;

    modport master (
        output lane_in, expect_val, clear,
        input  locked, fail, settle_cycles, glitch_count, mismatch_seen
    );

    modport slave (
        input  lane_in, expect_val, clear,
        output locked, fail, settle_cycles, glitch_count, mismatch_seen
    );
endinterface

// File: rtl/lane_settle_monitor.sv
// Settle/lock checker for an array of lane flops: measures settle latency
// after reset, then counts drop-outs while locked; FAIL is sticky.

// Per-lane input register and sticky mismatch flag.
module lane_settle_lane (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic lane_i,
    input  logic expect_i,
    input  logic upd_i,
    output logic diff_o,
    output logic seen_o
);
    logic lane_q;
    logic seen_q, seen_d;

    assign diff_o = lane_q ^ expect_i;
    assign seen_o = seen_q;

    always_comb begin
        seen_d = seen_q;
        if (clear_i)
            seen_d = 1'b0;
        else if (upd_i && diff_o)
            seen_d = 1'b1;
    end

    // lane_q keeps sampling during clear so the first post-clear compare is live
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            lane_q <= lane_i;
            seen_q <= seen_d;
        end
    end
endmodule

module lane_settle_monitor #(
    parameter int LANES     = 1,
    parameter int CNTW      = 8,
    parameter int TIMEOUT   = 16,
    parameter int RUN_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    lane_settle_monitor_if.slave  bus
);
    localparam int RUNW = (RUN_LIMIT < 2) ? 1 : $clog2(RUN_LIMIT + 1);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAIL   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNTW-1:0]  settle_q, settle_d;
    logic [CNTW-1:0]  glitch_q, glitch_d;
    logic [RUNW-1:0]  run_q, run_d;
    logic [LANES-1:0] diff;
    logic [LANES-1:0] seen;
    logic [CNTW-1:0]  settle_inc;
    logic [RUNW-1:0]  run_inc;
    logic             match;
    logic             in_locked;

    assign in_locked = (state_q == ST_LOCKED);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_settle_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear_i  (bus.clear),
            .lane_i   (bus.lane_in[g]),
            .expect_i (bus.expect_val[g]),
            .upd_i    (in_locked),
            .diff_o   (diff[g]),
            .seen_o   (seen[g])
        );
    end

    assign match      = ~|diff;
    assign settle_inc = settle_q + 1'b1;
    assign run_inc    = run_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        glitch_d = glitch_q;
        run_d    = run_q;
        if (bus.clear) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            glitch_d = '0;
            run_d    = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    // a match on the timeout edge still locks
                    if (match)
                        state_d = ST_LOCKED;
                    else begin
                        settle_d = settle_inc;
                        if (settle_inc == CNTW'(TIMEOUT))
                            state_d = ST_FAIL;
                    end
                end
                ST_LOCKED: begin
                    if (match)
                        run_d = '0;
                    else begin
                        if (glitch_q != '1)
                            glitch_d = glitch_q + 1'b1;
                        run_d = run_inc;
                        if (run_inc == RUNW'(RUN_LIMIT))
                            state_d = ST_FAIL;
                    end
                end
                default: state_d = ST_FAIL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            glitch_q <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            glitch_q <= glitch_d;
            run_q    <= run_d;
        end
    end

    assign bus.locked        = in_locked;
    assign bus.fail          = (state_q != ST_SETTLE) && (state_q != ST_LOCKED);
    assign bus.settle_cycles = settle_q;
    assign bus.glitch_count  = glitch_q;
    assign bus.mismatch_seen = seen;
endmodule

// File: tb/tb_lane_settle_monitor.sv
// Scoreboarded bench for lane_settle_monitor: a cycle model pushes expected
// outputs per edge, popped and compared just after the edge.
module tb_lane_settle_monitor;
    localparam int LANES     = 4;
    localparam int CNTW      = 8;
    localparam int TIMEOUT   = 16;
    localparam int RUN_LIMIT = 4;
    localparam int GMAX      = (1 << CNTW) - 1;

    typedef struct packed {
        logic             locked;
        logic             fail;
        logic [CNTW-1:0]  settle;
        logic [CNTW-1:0]  glitch;
        logic [LANES-1:0] seen;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    // model state: 0 settle, 1 locked, 2 fail
    int               m_state, m_settle, m_glitch, m_run;
    logic [LANES-1:0] m_lane_q, m_seen;

    lane_settle_monitor_if #(.LANES(LANES), .CNTW(CNTW)) bus ();

    lane_settle_monitor #(
        .LANES(LANES), .CNTW(CNTW), .TIMEOUT(TIMEOUT), .RUN_LIMIT(RUN_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_settle = 0; m_glitch = 0; m_run = 0;
        m_seen = '0; m_lane_q = '0;
    endtask

    task automatic model_edge();
        logic [LANES-1:0] d;
        d = m_lane_q ^ bus.expect_val;
        if (bus.clear) begin
            m_state = 0; m_settle = 0; m_glitch = 0; m_run = 0; m_seen = '0;
        end else begin
            case (m_state)
                0: if (d == '0) m_state = 1;
                   else begin
                       m_settle++;
                       if (m_settle == TIMEOUT) m_state = 2;
                   end
                1: if (d == '0) m_run = 0;
                   else begin
                       if (m_glitch < GMAX) m_glitch++;
                       m_seen |= d;
                       m_run++;
                       if (m_run == RUN_LIMIT) m_state = 2;
                   end
                default: ;
            endcase
        end
        m_lane_q = bus.lane_in;
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.locked = (m_state == 1);
        e.fail   = (m_state == 2);
        e.settle = CNTW'(m_settle);
        e.glitch = CNTW'(m_glitch);
        e.seen   = m_seen;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("locked", 32'(bus.locked), 32'(e.locked));
        chk("fail",   32'(bus.fail),   32'(e.fail));
        chk("settle", 32'(bus.settle_cycles), 32'(e.settle));
        chk("glitch", 32'(bus.glitch_count),  32'(e.glitch));
        chk("seen",   32'(bus.mismatch_seen), 32'(e.seen));
    endtask

    task automatic pulse_clear(input logic [LANES-1:0] lane);
        bus.lane_in = lane;
        bus.clear   = 1'b1;
        step();
        bus.clear   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.lane_in    = '1;
        bus.expect_val = '1;
        bus.clear      = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_fail",   32'(bus.fail), 0);
        chk("rst_settle", 32'(bus.settle_cycles), 0);
        chk("rst_seen",   32'(bus.mismatch_seen), 0);
        reset = 1'b0;

        // lock after second edge, settle 1
        step();
        chk("t1_not_yet", 32'(bus.locked), 0);
        step();
        chk("t1_locked", 32'(bus.locked), 1);
        chk("t1_settle", 32'(bus.settle_cycles), 1);

        // two mismatching cycles on lane 0
        bus.lane_in = 4'hE;
        step(); step();
        bus.lane_in = 4'hF;
        step(); step();
        chk("t3_glitch", 32'(bus.glitch_count), 2);
        chk("t3_seen",   32'(bus.mismatch_seen), 1);
        chk("t3_locked", 32'(bus.locked), 1);

        // four in a row -> FAIL (glitches accumulate on top of the earlier 2)
        bus.lane_in = 4'hE;
        repeat (5) step();
        chk("t4_fail",   32'(bus.fail), 1);
        chk("t4_locked", 32'(bus.locked), 0);
        chk("t4_glitch", 32'(bus.glitch_count), 6);
        bus.lane_in = 4'hF;
        repeat (3) step();
        chk("t4_sticky", 32'(bus.fail), 1);

        // clear out of FAIL, relock with settle 0
        pulse_clear(4'hF);
        chk("t5_fail",   32'(bus.fail), 0);
        chk("t5_glitch", 32'(bus.glitch_count), 0);
        step();
        chk("t5_locked", 32'(bus.locked), 1);
        chk("t5_settle", 32'(bus.settle_cycles), 0);

        // timeout
        pulse_clear(4'h0);
        repeat (15) step();
        chk("t2_pre_fail", 32'(bus.fail), 0);
        step();
        chk("t2_fail",   32'(bus.fail), 1);
        chk("t2_settle", 32'(bus.settle_cycles), 16);

        // match on the would-be timeout edge wins
        pulse_clear(4'h0);
        repeat (14) step();
        bus.lane_in = 4'hF;
        step();
        step();
        chk("tmo_match_locked", 32'(bus.locked), 1);
        chk("tmo_match_settle", 32'(bus.settle_cycles), 15);

        // expect_val change while locked is an ordinary mismatch
        bus.expect_val = 4'h7;
        step();
        bus.expect_val = 4'hF;
        step();
        chk("exp_chg_seen",   32'(bus.mismatch_seen), 32'h8);
        chk("exp_chg_glitch", 32'(bus.glitch_count), 1);

        // glitch_count saturation via runs of 3 mismatches
        pulse_clear(4'hF);
        step();
        for (int i = 0; i < 90; i++) begin
            bus.lane_in = 4'h5;
            repeat (3) step();
            bus.lane_in = 4'hF;
            step();
        end
        step();
        chk("sat_glitch", 32'(bus.glitch_count), GMAX);
        chk("sat_locked", 32'(bus.locked), 1);
        chk("sat_seen",   32'(bus.mismatch_seen), 32'hA);

        // random traffic with occasional clears
        for (int i = 0; i < 200; i++) begin
            bus.clear   = ($urandom_range(19) == 0);
            bus.lane_in = ($urandom_range(2) != 0) ? 4'hF : 4'($urandom_range(15));
            step();
        end
        bus.clear = 1'b0;

        // async reset between edges while locked
        pulse_clear(4'hF);
        step();
        bus.lane_in = 4'h3;
        step(); step();
        bus.lane_in = 4'hF;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_locked", 32'(bus.locked), 0);
        chk("t6_glitch", 32'(bus.glitch_count), 0);
        chk("t6_settle", 32'(bus.settle_cycles), 0);
        chk("t6_seen",   32'(bus.mismatch_seen), 0);
        chk("t6_fail",   32'(bus.fail), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(); step();
        chk("t6_relock",  32'(bus.locked), 1);
        chk("t6_resettle", 32'(bus.settle_cycles), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
